fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_write  in  1  from hazard unit; 0 = hold PC and issue no fetch.
- ifid_write  in  1  from hazard unit; 0 = hold IF/ID outputs.
- flush  in  1  taken-branch redirect.
- branch_target  in  16  redirect PC, word address.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch word address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; exactly 1 cycle after a grant.
- imem_rdata  in  16  instruction word.
- if_id_instr  out  16  IF/ID instruction.
- if_id_pc  out  16  IF/ID instruction address.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_rn1  out  4  if_id_instr[7:4], combinational.
- if_id_rn2  out  4  if_id_instr[3:0], combinational.

Function
REQ-002 SHALL drive imem_addr = PC; imem_req = pc_write & ~flush & (~hold_valid | ifid_write).
REQ-003 SHALL define issue = imem_req & imem_gnt; on issue PC <= PC+1, 16-bit wrap (16'hFFFF -> 16'h0000), and rsp_pc <= PC.
REQ-004 SHALL keep PC unchanged when no issue occurs, including when pc_write=0.
REQ-005 SHALL accept imem_rdata only when imem_rvalid=1 and the drop flag is clear; otherwise the response is ignored.
REQ-006 SHALL, with ifid_write=1, load IF/ID in priority order: hold buffer (then clear hold_valid); else accepted response; else a bubble (valid=0, instr=16'h0000, pc unchanged).
REQ-007 SHALL, with ifid_write=0, hold IF/ID and write an accepted response with its rsp_pc into the one-entry hold buffer (hold_valid <= 1).
REQ-008 SHALL give flush priority over stall: PC <= branch_target, if_id_valid <= 0, if_id_instr <= 0, hold_valid <= 0, drop <= 1 when a fetch is outstanding; no issue that cycle.
REQ-009 SHALL clear drop in the cycle its discarded response arrives; a flush with nothing outstanding does not set drop.
REQ-010 SHALL produce IF/ID 2 cycles after issue with no stall (issue N, rvalid N+1, IF/ID visible N+2).
REQ-011 SHALL treat imem_rvalid=1 while hold_valid=1 and ifid_write=0 as illegal (unreachable by REQ-002); flagged by a bench assertion.
REQ-012 SHALL sustain one instruction per cycle while imem_gnt=1 and no stall or flush.

Reset
REQ-013 SHALL, on rst_n=0, immediately set PC=16'h0000, if_id_instr=16'h0000, if_id_pc=16'h0000, if_id_valid=0, hold_valid=0, drop=0, rsp_pc=0.
REQ-014 SHALL discard any response arriving in the first cycle after reset release; imem_req may assert that cycle.
REQ-015 SHALL abandon an in-flight fetch when reset asserts mid-operation, leaving no residual state.

Structure
REQ-016 SHALL take from the shared core package: XLEN_PC=16, INSTR_W=16, REG_IDX_W=4, NOP_INSTR=16'h0000, RESET_PC=16'h0000, and field positions RN1_MSB/LSB and RN2_MSB/LSB.
REQ-017 SHALL use one sub-module, fetch_hold_buf (1-entry instr+pc skid buffer); the PC and IF/ID registers stay in the top.

Verification
REQ-018 Free-run, gnt=1, mem[i]=i+16'h1000 -> if_id_pc 0,1,2,... from cycle 2 after reset, valid=1 every cycle.
REQ-019 Issue at PC=5; cycle N+1 ifid_write=pc_write=0 for 3 cycles -> instr@5 enters hold, no req, PC=6; after release IF/ID=instr@5 then instr@6, none lost or duplicated.
REQ-020 Flush with branch_target=16'h0040 while fetch@9 is in flight -> response@9 dropped, if_id_valid=0 next cycle, next if_id_pc=16'h0040.
REQ-021 Simultaneous flush and pc_write=0 -> PC=branch_target, hold cleared, no req that cycle.
REQ-022 PC=16'hFFFF, gnt=1 -> fetch FFFF then 0000; if_id_pc wraps cleanly.
REQ-023 gnt=0 for 4 cycles, then rst_n pulsed low mid-stream -> no PC advance during gnt=0; all outputs return to zero immediately, fetch restarts at 0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared core constants and types for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int XLEN_PC   = 16;
  localparam int INSTR_W   = 16;
  localparam int REG_IDX_W = 4;

  localparam int RN1_MSB = 7;
  localparam int RN1_LSB = 4;
  localparam int RN2_MSB = 3;
  localparam int RN2_LSB = 0;

  typedef logic [XLEN_PC-1:0] pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR = 16'h0000;
  localparam pc_t    RESET_PC  = 16'h0000;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_ent_t;

  typedef enum logic [1:0] {
    IFID_SRC_BUBBLE = 2'd0,
    IFID_SRC_HOLD   = 2'd1,
    IFID_SRC_RSP    = 2'd2
  } ifid_src_e;

  function automatic pc_t pc_next(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Hazard-control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                 pc_write;
  logic                 ifid_write;
  logic                 flush;
  logic [XLEN_PC-1:0]   branch_target;

  logic                 imem_req;
  logic [XLEN_PC-1:0]   imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [INSTR_W-1:0]   imem_rdata;

  logic [INSTR_W-1:0]   if_id_instr;
  logic [XLEN_PC-1:0]   if_id_pc;
  logic                 if_id_valid;
  logic [REG_IDX_W-1:0] if_id_rn1;
  logic [REG_IDX_W-1:0] if_id_rn2;

  modport master (
    input  pc_write, ifid_write, flush, branch_target,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr,
    output if_id_instr, if_id_pc, if_id_valid, if_id_rn1, if_id_rn2
  );

  modport slave (
    output pc_write, ifid_write, flush, branch_target,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr,
    input  if_id_instr, if_id_pc, if_id_valid, if_id_rn1, if_id_rn2
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry instr+pc skid buffer catching a response that arrives while IF/ID is stalled.
// Clear wins over write; write wins over read so a drain-and-refill keeps the new entry.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_wr,
  input  fetch_ent_t i_wr_ent,
  input  logic       i_rd,
  output logic       o_vld,
  output fetch_ent_t o_ent
);

  logic       r_vld;
  fetch_ent_t r_ent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_ent <= '0;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (i_wr) begin
      r_vld <= 1'b1;
      r_ent <= i_wr_ent;
    end else if (i_rd) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_ent = r_ent;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, memory request, response capture and the IF/ID register.
// Memory answers exactly one cycle after a grant, so at most one fetch is in flight.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  pc_t        r_pc;
  pc_t        r_rsp_pc;
  logic       r_pending;
  logic       r_drop;
  instr_t     r_if_id_instr;
  pc_t        r_if_id_pc;
  logic       r_if_id_valid;

  logic       w_req;
  logic       w_issue;
  logic       w_accept;
  logic       w_hold_vld;
  logic       w_hold_wr;
  fetch_ent_t w_hold_ent;
  fetch_ent_t w_rsp_ent;
  ifid_src_e  w_src;

  assign w_req   = bus.pc_write & ~bus.flush & (~w_hold_vld | bus.ifid_write);
  assign w_issue = w_req & bus.imem_gnt;

  // r_pending also rejects stray responses right after reset release
  assign w_accept  = bus.imem_rvalid & r_pending & ~r_drop;
  assign w_rsp_ent = '{instr: bus.imem_rdata, pc: r_rsp_pc};
  assign w_hold_wr = w_accept & (~bus.ifid_write | w_hold_vld);

  always_comb begin
    w_src = IFID_SRC_BUBBLE;
    if (w_hold_vld) begin
      w_src = IFID_SRC_HOLD;
    end else if (w_accept) begin
      w_src = IFID_SRC_RSP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_rsp_pc  <= RESET_PC;
      r_pending <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_pc <= bus.branch_target;
      end else if (w_issue) begin
        r_pc     <= pc_next(r_pc);
        r_rsp_pc <= r_pc;
      end
      r_pending <= w_issue;
      if (r_drop && bus.imem_rvalid) begin
        r_drop <= 1'b0;
      end else if (bus.flush && r_pending && !bus.imem_rvalid) begin
        r_drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc    <= RESET_PC;
      r_if_id_valid <= 1'b0;
    end else if (bus.flush) begin
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (bus.ifid_write) begin
      case (w_src)
        IFID_SRC_HOLD: begin
          r_if_id_instr <= w_hold_ent.instr;
          r_if_id_pc    <= w_hold_ent.pc;
          r_if_id_valid <= 1'b1;
        end
        IFID_SRC_RSP: begin
          r_if_id_instr <= w_rsp_ent.instr;
          r_if_id_pc    <= w_rsp_ent.pc;
          r_if_id_valid <= 1'b1;
        end
        default: begin
          r_if_id_instr <= NOP_INSTR;
          r_if_id_valid <= 1'b0;
        end
      endcase
    end
  end

  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (bus.flush),
    .i_wr     (w_hold_wr),
    .i_wr_ent (w_rsp_ent),
    .i_rd     (bus.ifid_write),
    .o_vld    (w_hold_vld),
    .o_ent    (w_hold_ent)
  );

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.if_id_instr = r_if_id_instr;
  assign bus.if_id_pc    = r_if_id_pc;
  assign bus.if_id_valid = r_if_id_valid;
  assign bus.if_id_rn1   = r_if_id_instr[RN1_MSB:RN1_LSB];
  assign bus.if_id_rn2   = r_if_id_instr[RN2_MSB:RN2_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench: stimulus queues expected IF/ID entries, a monitor pops them as IF/ID loads.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stray = 1'b0;
  logic last_ifw = 1'b0;
  logic        r_mem_vld = 1'b0;
  logic [15:0] r_mem_dat = 16'h0000;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // memory: mem[a] = a + 0x1000, data one cycle after grant; not reset on purpose
  always @(posedge clk) begin
    r_mem_vld <= bus.imem_req & bus.imem_gnt;
    r_mem_dat <= bus.imem_addr + 16'h1000;
  end
  assign bus.imem_rvalid = r_mem_vld | stray;
  assign bus.imem_rdata  = stray ? 16'hDEAD : r_mem_dat;

  always @(posedge clk) last_ifw <= bus.ifid_write;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr);
    exp_q.push_back('{pc: pc, instr: instr});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout actual=%0d entries left required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && last_ifw && bus.if_id_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ifid actual pc=%h instr=%h required none", bus.if_id_pc, bus.if_id_instr);
      end else begin
        e = exp_q.pop_front();
        chk("ifid_pc", bus.if_id_pc, e.pc);
        chk("ifid_instr", bus.if_id_instr, e.instr);
        chk("ifid_rn1", 16'(bus.if_id_rn1), 16'(e.instr[7:4]));
        chk("ifid_rn2", 16'(bus.if_id_rn2), 16'(e.instr[3:0]));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.imem_rvalid && dut.u_hold.o_vld && !bus.ifid_write))
      else begin
        n_fail++;
        $display("FAIL illegal_rvalid_into_full_hold actual=1 required=0 at %0t", $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc_write      = 1'b1;
    bus.ifid_write    = 1'b1;
    bus.flush         = 1'b0;
    bus.branch_target = 16'h0000;
    bus.imem_gnt      = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_valid", 16'(bus.if_id_valid), 16'h0);
    chk("rst_instr", bus.if_id_instr, 16'h0000);
    chk("rst_pc", bus.if_id_pc, 16'h0000);
    chk("rst_addr", bus.imem_addr, 16'h0000);

    rst_n = 1'b1;
    stray = 1'b1;
    #1 chk("req_after_release", 16'(bus.imem_req), 16'h1);
    @(negedge clk);
    stray = 1'b0;
    chk("stray_ignored", 16'(bus.if_id_valid), 16'h0);
    chk("addr_gnt0", bus.imem_addr, 16'h0000);

    for (int i = 0; i < 8; i++) push(16'(i), 16'h1000 + 16'(i));
    bus.imem_gnt = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 9) chk("free_valid", 16'(bus.if_id_valid), 16'h1);
      if (i == 8) bus.imem_gnt = 1'b0;
    end
    chk("free_bubble", 16'(bus.if_id_valid), 16'h0);
    chk("free_addr", bus.imem_addr, 16'h0008);
    drain();

    @(negedge clk);
    bus.flush = 1'b1;
    bus.branch_target = 16'h0005;
    #1 chk("flush_idle_req", 16'(bus.imem_req), 16'h0);
    @(negedge clk);
    bus.flush = 1'b0;
    push(16'h0005, 16'h1005);
    push(16'h0006, 16'h1006);
    bus.imem_gnt = 1'b1;
    #1 chk("redirect_addr5", bus.imem_addr, 16'h0005);
    @(negedge clk);
    bus.pc_write = 1'b0;
    bus.ifid_write = 1'b0;
    @(negedge clk);
    #1;
    chk("stall_addr", bus.imem_addr, 16'h0006);
    chk("stall_req", 16'(bus.imem_req), 16'h0);
    chk("stall_ifid_valid", 16'(bus.if_id_valid), 16'h0);
    repeat (2) @(negedge clk);
    bus.pc_write = 1'b1;
    bus.ifid_write = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    drain();
    chk("after_stall_addr", bus.imem_addr, 16'h0007);

    @(negedge clk);
    push(16'h0007, 16'h1007);
    push(16'h0008, 16'h1008);
    push(16'h0040, 16'h1040);
    bus.imem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    bus.branch_target = 16'h0040;
    #1 chk("flush_req", 16'(bus.imem_req), 16'h0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_bubble", 16'(bus.if_id_valid), 16'h0);
    chk("flush_addr", bus.imem_addr, 16'h0040);
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    drain();

    @(negedge clk);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.pc_write = 1'b0;
    bus.ifid_write = 1'b0;
    @(negedge clk);
    bus.flush = 1'b1;
    bus.branch_target = 16'h0100;
    #1;
    chk("flush_stall_req", 16'(bus.imem_req), 16'h0);
    chk("hold_loaded", 16'(dut.u_hold.o_vld), 16'h1);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.pc_write = 1'b1;
    bus.ifid_write = 1'b1;
    bus.imem_gnt = 1'b0;
    chk("flush_stall_addr", bus.imem_addr, 16'h0100);
    chk("flush_stall_valid", 16'(bus.if_id_valid), 16'h0);
    @(negedge clk);
    chk("hold_cleared_valid", 16'(bus.if_id_valid), 16'h0);

    @(negedge clk);
    bus.flush = 1'b1;
    bus.branch_target = 16'hFFFF;
    @(negedge clk);
    bus.flush = 1'b0;
    push(16'hFFFF, 16'h0FFF);
    push(16'h0000, 16'h1000);
    bus.imem_gnt = 1'b1;
    #1 chk("wrap_addr_ffff", bus.imem_addr, 16'hFFFF);
    @(negedge clk);
    chk("wrap_addr_0", bus.imem_addr, 16'h0000);
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    chk("wrap_addr_1", bus.imem_addr, 16'h0001);
    drain();

    repeat (4) @(negedge clk);
    chk("gnt0_no_advance", bus.imem_addr, 16'h0001);
    chk("gnt0_req", 16'(bus.imem_req), 16'h1);
    push(16'h0001, 16'h1001);
    push(16'h0002, 16'h1002);
    bus.imem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 16'(bus.if_id_valid), 16'h0);
    chk("rst_mid_instr", bus.if_id_instr, 16'h0000);
    chk("rst_mid_pc", bus.if_id_pc, 16'h0000);
    chk("rst_mid_addr", bus.imem_addr, 16'h0000);
    chk("rst_mid_rn1", 16'(bus.if_id_rn1), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(16'h0000, 16'h1000);
    push(16'h0001, 16'h1001);
    repeat (2) @(negedge clk);
    bus.imem_gnt = 1'b0;
    drain();
    chk("restart_addr", bus.imem_addr, 16'h0002);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
